// File: rtl/mc_pkg.sv
// Shared definitions for the mc_ctrl32 multicycle sequencer: state codes,
// PC-source codes, Minisys-1A opcode/funct/rt constants and instruction classes.
package mc_pkg;

  // Sequencer states; the numeric codes are visible on the debug port
  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_INT = 3'd5
  } state_t;

  // PC source select driven onto Wpc
  localparam logic [1:0] WPC_HOLD = 2'b00;
  localparam logic [1:0] WPC_SEQ  = 2'b10;
  localparam logic [1:0] WPC_JMP  = 2'b01;
  localparam logic [1:0] WPC_BR   = 2'b11;

  // Primary opcodes, instruction[31:26]
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LH     = 6'b100001;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_LBU    = 6'b100100;
  localparam logic [5:0] OP_LHU    = 6'b100101;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SH     = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // R-type function codes that change control flow
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  // REGIMM rt selectors
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  // Instruction classes as seen by the sequencer
  typedef enum logic [3:0] {
    CL_ILLEGAL = 4'd0,
    CL_ALU_R   = 4'd1,
    CL_ALU_I   = 4'd2,
    CL_LOAD    = 4'd3,
    CL_STORE   = 4'd4,
    CL_BRANCH  = 4'd5,
    CL_J       = 4'd6,
    CL_JAL     = 4'd7,
    CL_JR      = 4'd8,
    CL_JALR    = 4'd9
  } iclass_t;

  // Where the sequencer goes after a PC-committing cycle: interrupt entry
  // if a request is pending, otherwise the next fetch.
  function automatic state_t boundary_next(input logic int_req);
    return int_req ? S_INT : S_IF;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier for mc_ctrl32. Maps the IR fields
// opcode/funct/rt onto an instruction class, flags the REGIMM link forms
// (bltzal/bgezal) and marks anything it cannot classify as illegal.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  output logic [3:0] iclass,
  output logic       is_link,
  output logic       is_illegal
);

  iclass_t cls;

  // Classify the instruction; unknown encodings fall through as illegal
  always_comb begin
    cls     = CL_ILLEGAL;
    is_link = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_JR) begin
          cls = CL_JR;
        end else if (funct == FN_JALR) begin
          cls = CL_JALR;
        end else begin
          cls = CL_ALU_R;
        end
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ: begin
            cls = CL_BRANCH;
          end
          RT_BLTZAL, RT_BGEZAL: begin
            cls     = CL_BRANCH;
            is_link = 1'b1;
          end
          default: begin
            cls = CL_ILLEGAL;
          end
        endcase
      end
      OP_J:   cls = CL_J;
      OP_JAL: cls = CL_JAL;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        cls = CL_BRANCH;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        cls = CL_ALU_I;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        cls = CL_LOAD;
      end
      OP_SB, OP_SH, OP_SW: begin
        cls = CL_STORE;
      end
      default: begin
        cls = CL_ILLEGAL;
      end
    endcase
  end

  assign iclass     = cls;
  assign is_illegal = (cls == CL_ILLEGAL);

endmodule

// File: rtl/mc_ctrl32.sv
// mc_ctrl32: multicycle control sequencer for the Minisys-1A core.
// Steps one instruction at a time through IF/ID/EX/MEM/WB, stretching IF by
// IF_WAIT cycles for slow program ROM and MEM until mem_ready. Interrupt
// requests are taken only on the cycle that commits the PC, via a one-cycle
// INT state. Outputs are decoded from the registered state (plus the
// datapath condition inputs) and are forced low while reset is asserted.
// Build option: define MC_PERF_CNT_EN to add the cyc_cnt/ret_cnt
// performance counters (CNT_W bits wide); without it the ports and the
// CNT_W parameter do not exist.
module mc_ctrl32
  import mc_pkg::*;
#(
  parameter int IF_WAIT = 0
`ifdef MC_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic       branch_taken,
  input  logic       mem_ready,
  input  logic       int_req,
  output logic       Wir,
  output logic [1:0] Wpc,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       flush,
  output logic       int_ack,
  output logic       illegal,
  output logic [2:0] state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt
`endif
);

  localparam logic [3:0] IF_LAST = 4'(IF_WAIT);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] wait_q;
  logic       taken_q;
  logic       if_done;
  logic [3:0] cls_bits;
  iclass_t    cls;
  logic       is_link;
  logic       is_illegal;

  mc_decode u_decode (
    .opcode     (opcode),
    .funct      (funct),
    .rt         (rt),
    .iclass     (cls_bits),
    .is_link    (is_link),
    .is_illegal (is_illegal)
  );

  assign cls     = iclass_t'(cls_bits);
  assign if_done = (wait_q == IF_LAST);
  assign state   = state_q;

  // State register; reset abandons whatever instruction was in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // IF stretch counter and the branch condition captured in EX for link branches
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_q  <= 4'd0;
      taken_q <= 1'b0;
    end else begin
      if (state_q == S_IF && !if_done) begin
        wait_q <= wait_q + 4'd1;
      end else begin
        wait_q <= 4'd0;
      end
      if (state_q == S_EX) begin
        taken_q <= branch_taken;
      end
    end
  end

  // Next-state selection; every PC-committing cycle is an interrupt boundary
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: begin
        if (if_done) begin
          state_d = S_ID;
        end
      end
      S_ID: begin
        if (is_illegal) begin
          state_d = boundary_next(int_req);
        end else begin
          case (cls)
            CL_J, CL_JR:     state_d = boundary_next(int_req);
            CL_JAL, CL_JALR: state_d = S_WB;
            default:         state_d = S_EX;
          endcase
        end
      end
      S_EX: begin
        case (cls)
          CL_BRANCH:         state_d = is_link ? S_WB : boundary_next(int_req);
          CL_LOAD, CL_STORE: state_d = S_MEM;
          default:           state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = (cls == CL_LOAD) ? S_WB : boundary_next(int_req);
        end
      end
      S_WB: begin
        state_d = boundary_next(int_req);
      end
      S_INT: begin
        state_d = S_IF;
      end
      default: begin
        state_d = S_IF;
      end
    endcase
  end

  // Moore-style strobe decode; everything stays low while reset is held
  always_comb begin
    Wir      = 1'b0;
    Wpc      = WPC_HOLD;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    flush    = 1'b0;
    int_ack  = 1'b0;
    illegal  = 1'b0;
    if (reset) begin
      case (state_q)
        S_IF: begin
          Wir = if_done;
        end
        S_ID: begin
          if (is_illegal) begin
            illegal = 1'b1;
            PCWrite = 1'b1;
            Wpc     = WPC_SEQ;
          end else if (cls == CL_J || cls == CL_JR) begin
            PCWrite = 1'b1;
            Wpc     = WPC_JMP;
          end
        end
        S_EX: begin
          if (cls == CL_BRANCH && !is_link) begin
            PCWrite = 1'b1;
            Wpc     = branch_taken ? WPC_BR : WPC_SEQ;
          end
        end
        S_MEM: begin
          MemRead  = (cls == CL_LOAD);
          MemWrite = (cls == CL_STORE);
          if (mem_ready && cls == CL_STORE) begin
            PCWrite = 1'b1;
            Wpc     = WPC_SEQ;
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          case (cls)
            CL_JAL, CL_JALR: Wpc = WPC_JMP;
            CL_BRANCH:       Wpc = taken_q ? WPC_BR : WPC_SEQ;
            default:         Wpc = WPC_SEQ;
          endcase
        end
        S_INT: begin
          flush   = 1'b1;
          PCWrite = 1'b1;
          Wpc     = WPC_SEQ;
          int_ack = 1'b1;
        end
        default: begin
          Wpc = WPC_HOLD;
        end
      endcase
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] ret_q;

  // Free-running cycle count and count of retired instructions (PC commits outside INT)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (PCWrite && state_q != S_INT) begin
        ret_q <= ret_q + CNT_W'(1);
      end
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_mc_ctrl32.sv
// Self-checking bench for mc_ctrl32. A per-instruction behavioural model
// expands each directed instruction into its expected cycle trace (inputs
// and strobes); one compare process checks the IF_WAIT=0 instance against
// that trace on every falling edge. A second instance with IF_WAIT=3 shares
// the inputs and is checked with literal values after an async reset.
module tb_mc_ctrl32;

  localparam int IF_WAIT_A = 0;
  localparam int IF_WAIT_B = 3;

  localparam int K_ALU    = 0;
  localparam int K_LOAD   = 1;
  localparam int K_STORE  = 2;
  localparam int K_BR     = 3;
  localparam int K_LINKBR = 4;
  localparam int K_JMP    = 5;
  localparam int K_JLINK  = 6;
  localparam int K_ILL    = 7;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    logic       bt;
    logic       mr;
    logic       irq;
    int         st;
    logic       wir;
    logic [1:0] wpc;
    logic       pcw;
    logic       rw;
    logic       mrd;
    logic       mwr;
    logic       fl;
    logic       ack;
    logic       ill;
  } cyc_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic [4:0] rt = 5'd0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       int_req = 1'b0;

  logic       wir_a, pcw_a, rw_a, mrd_a, mwr_a, flush_a, ack_a, ill_a;
  logic [1:0] wpc_a;
  logic [2:0] state_a;
  logic       wir_b, pcw_b, rw_b, mrd_b, mwr_b, flush_b, ack_b, ill_b;
  logic [1:0] wpc_b;
  logic [2:0] state_b;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_a, ret_a, cyc_b, ret_b;
`endif

  cyc_t       prog[$];
  cyc_t       cur;
  bit         cur_valid = 1'b0;
  int         cyc_no = 0;
  int         checks = 0;
  int         failures = 0;
  logic [5:0] b_op;
  logic [5:0] b_fn;
  logic [4:0] b_rt;

  mc_ctrl32 #(.IF_WAIT(IF_WAIT_A)) dut_a (
    .clock        (clock),
    .reset        (reset),
    .opcode       (opcode),
    .funct        (funct),
    .rt           (rt),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .int_req      (int_req),
`ifdef MC_PERF_CNT_EN
    .cyc_cnt      (cyc_a),
    .ret_cnt      (ret_a),
`endif
    .Wir          (wir_a),
    .Wpc          (wpc_a),
    .PCWrite      (pcw_a),
    .RegWrite     (rw_a),
    .MemRead      (mrd_a),
    .MemWrite     (mwr_a),
    .flush        (flush_a),
    .int_ack      (ack_a),
    .illegal      (ill_a),
    .state        (state_a)
  );

  mc_ctrl32 #(.IF_WAIT(IF_WAIT_B)) dut_b (
    .clock        (clock),
    .reset        (reset),
    .opcode       (opcode),
    .funct        (funct),
    .rt           (rt),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .int_req      (int_req),
`ifdef MC_PERF_CNT_EN
    .cyc_cnt      (cyc_b),
    .ret_cnt      (ret_b),
`endif
    .Wir          (wir_b),
    .Wpc          (wpc_b),
    .PCWrite      (pcw_b),
    .RegWrite     (rw_b),
    .MemRead      (mrd_b),
    .MemWrite     (mwr_b),
    .flush        (flush_b),
    .int_ack      (ack_b),
    .illegal      (ill_b),
    .state        (state_b)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Instruction class straight from the ISA tables, using opcode ranges
  function automatic int classify(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r);
    if (op == 6'd0) begin
      if (fn == 6'b001000) return K_JMP;
      if (fn == 6'b001001) return K_JLINK;
      return K_ALU;
    end
    if (op == 6'd1) begin
      if (r == 5'b00000 || r == 5'b00001) return K_BR;
      if (r == 5'b10000 || r == 5'b10001) return K_LINKBR;
      return K_ILL;
    end
    if (op == 6'd2) return K_JMP;
    if (op == 6'd3) return K_JLINK;
    if (op >= 6'd4 && op <= 6'd7) return K_BR;
    if (op >= 6'd8 && op <= 6'd15) return K_ALU;
    if (op inside {6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101}) return K_LOAD;
    if (op inside {6'b101000, 6'b101001, 6'b101011}) return K_STORE;
    return K_ILL;
  endfunction

  task automatic push(input int st, input logic wir, input logic [1:0] wpc,
                      input logic pcw, input logic rw, input logic mrd, input logic mwr,
                      input logic fl, input logic ack, input logic ill,
                      input logic bt, input logic mr, input logic irq);
    cyc_t e;
    e.op = b_op; e.fn = b_fn; e.rt = b_rt;
    e.bt = bt; e.mr = mr; e.irq = irq;
    e.st = st; e.wir = wir; e.wpc = wpc; e.pcw = pcw; e.rw = rw;
    e.mrd = mrd; e.mwr = mwr; e.fl = fl; e.ack = ack; e.ill = ill;
    prog.push_back(e);
  endtask

  // Expand one instruction into its expected cycle trace. int_req (if used)
  // is raised from ID onward and dropped during the INT cycle; mem_ready is
  // high outside MEM; branch_taken carries the condition only in EX.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r,
                       input logic taken, input int mem_wait, input logic irq);
    int         k;
    logic       nt;
    logic       to_wb;
    logic [1:0] wb_wpc;
    k = classify(op, fn, r);
    b_op = op; b_fn = fn; b_rt = r;
    nt = ~taken;
    to_wb = 1'b0;
    wb_wpc = 2'b10;
    for (int i = 0; i <= IF_WAIT_A; i++)
      push(0, (i == IF_WAIT_A), 2'b00, 0, 0, 0, 0, 0, 0, 0, nt, 1, 0);
    if (k == K_JMP) begin
      push(1, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0, nt, 1, irq);
    end else if (k == K_ILL) begin
      push(1, 0, 2'b10, 1, 0, 0, 0, 0, 0, 1, nt, 1, irq);
    end else if (k == K_JLINK) begin
      push(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, nt, 1, irq);
      to_wb = 1'b1;
      wb_wpc = 2'b01;
    end else begin
      push(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, nt, 1, irq);
      if (k == K_BR) begin
        push(2, 0, taken ? 2'b11 : 2'b10, 1, 0, 0, 0, 0, 0, 0, taken, 1, irq);
      end else begin
        push(2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, taken, 1, irq);
        if (k == K_LINKBR) begin
          to_wb = 1'b1;
          wb_wpc = taken ? 2'b11 : 2'b10;
        end else if (k == K_ALU) begin
          to_wb = 1'b1;
        end else begin
          for (int i = 0; i < mem_wait; i++)
            push(3, 0, 2'b00, 0, 0, k == K_LOAD, k == K_STORE, 0, 0, 0, nt, 0, irq);
          if (k == K_LOAD) begin
            push(3, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, nt, 1, irq);
            to_wb = 1'b1;
          end else begin
            push(3, 0, 2'b10, 1, 0, 0, 1, 0, 0, 0, nt, 1, irq);
          end
        end
      end
    end
    if (to_wb) push(4, 0, wb_wpc, 1, 1, 0, 0, 0, 0, 0, nt, 1, irq);
    if (irq) push(5, 0, 2'b10, 1, 0, 0, 0, 1, 1, 0, nt, 1, 0);
  endtask

  task automatic buildPinned(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic [4:0] r, input logic taken, input int mem_wait,
                             input logic irq, input int exp_len);
    int n0;
    n0 = prog.size();
    build(op, fn, r, taken, mem_wait, irq);
    checkOutput({"len_", name}, 32'(prog.size() - n0), 32'(exp_len));
  endtask

  // Play the trace: each entry covers one clock cycle starting just after a rising edge
  task automatic applyStimulus();
    cyc_t e;
    while (prog.size() > 0) begin
      e = prog.pop_front();
      opcode = e.op; funct = e.fn; rt = e.rt;
      branch_taken = e.bt; mem_ready = e.mr; int_req = e.irq;
      cur = e;
      cur_valid = 1'b1;
      cyc_no++;
      @(posedge clock);
      #1;
    end
    cur_valid = 1'b0;
  endtask

  initial begin
    int n;
    int a_st[5]  = '{0, 1, 2, 3, 3};
    int a_wir[5] = '{1, 0, 0, 0, 0};
    int a_mwr[5] = '{0, 0, 0, 1, 1};
    int b_st[5]  = '{0, 0, 0, 0, 1};
    int b_wir[5] = '{0, 0, 0, 1, 0};

    fork
      forever begin
        @(negedge clock);
        if (cur_valid) begin
          string t;
          t = $sformatf("c%0d", cyc_no);
          checkOutput({t, "_state"},    32'(state_a), 32'(cur.st));
          checkOutput({t, "_Wir"},      32'(wir_a),   32'(cur.wir));
          checkOutput({t, "_Wpc"},      32'(wpc_a),   32'(cur.wpc));
          checkOutput({t, "_PCWrite"},  32'(pcw_a),   32'(cur.pcw));
          checkOutput({t, "_RegWrite"}, 32'(rw_a),    32'(cur.rw));
          checkOutput({t, "_MemRead"},  32'(mrd_a),   32'(cur.mrd));
          checkOutput({t, "_MemWrite"}, 32'(mwr_a),   32'(cur.mwr));
          checkOutput({t, "_flush"},    32'(flush_a), 32'(cur.fl));
          checkOutput({t, "_int_ack"},  32'(ack_a),   32'(cur.ack));
          checkOutput({t, "_illegal"},  32'(ill_a),   32'(cur.ill));
        end
      end
    join_none

    // Held in reset: every strobe low, state reads IF, on both instances
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_state_a", 32'(state_a), 32'd0);
    checkOutput("rst_Wir_a",   32'(wir_a),   32'd0);
    checkOutput("rst_Wpc_a",   32'(wpc_a),   32'd0);
    checkOutput("rst_PCW_a",   32'(pcw_a),   32'd0);
    checkOutput("rst_RegW_a",  32'(rw_a),    32'd0);
    checkOutput("rst_MemR_a",  32'(mrd_a),   32'd0);
    checkOutput("rst_MemW_a",  32'(mwr_a),   32'd0);
    checkOutput("rst_flush_a", 32'(flush_a), 32'd0);
    checkOutput("rst_ack_a",   32'(ack_a),   32'd0);
    checkOutput("rst_ill_a",   32'(ill_a),   32'd0);
    checkOutput("rst_state_b", 32'(state_b), 32'd0);
    checkOutput("rst_Wir_b",   32'(wir_b),   32'd0);

    // Directed program; lengths of key classes pinned to hand-counted cycles
    buildPinned("add",     6'b000000, 6'b100000, 5'd0, 1'b0, 0, 1'b0, 4);
    buildPinned("lw_w3",   6'b100011, 6'd0,      5'd0, 1'b0, 3, 1'b0, 8);
    buildPinned("sw",      6'b101011, 6'd0,      5'd0, 1'b0, 0, 1'b0, 4);
    build(6'b101011, 6'd0, 5'd0, 1'b0, 2, 1'b0);
    buildPinned("beq_t",   6'b000100, 6'd0,      5'd0, 1'b1, 0, 1'b0, 3);
    build(6'b000100, 6'd0, 5'd0, 1'b0, 0, 1'b0);
    build(6'b000101, 6'd0, 5'd0, 1'b1, 0, 1'b0);
    build(6'b000110, 6'd0, 5'd0, 1'b0, 0, 1'b0);
    buildPinned("j",       6'b000010, 6'd0,      5'd0, 1'b0, 0, 1'b0, 2);
    build(6'b000000, 6'b001000, 5'd0, 1'b0, 0, 1'b0);
    buildPinned("jal",     6'b000011, 6'd0,      5'd0, 1'b0, 0, 1'b0, 3);
    build(6'b000000, 6'b001001, 5'd0, 1'b0, 0, 1'b0);
    build(6'b000001, 6'd0, 5'b10000, 1'b1, 0, 1'b0);
    build(6'b000001, 6'd0, 5'b10001, 1'b0, 0, 1'b0);
    build(6'b000001, 6'd0, 5'b00001, 1'b1, 0, 1'b0);
    build(6'b001000, 6'd0, 5'd0, 1'b0, 0, 1'b0);
    build(6'b001111, 6'd0, 5'd0, 1'b0, 0, 1'b0);
    buildPinned("add_irq", 6'b000000, 6'b100000, 5'd0, 1'b0, 0, 1'b1, 5);
    buildPinned("ill_irq", 6'b111111, 6'd0,      5'd0, 1'b0, 0, 1'b1, 3);
    build(6'b100100, 6'd0, 5'd0, 1'b0, 1, 1'b1);
    build(6'b000010, 6'd0, 5'd0, 1'b0, 0, 1'b1);
    build(6'b101000, 6'd0, 5'd0, 1'b0, 1, 1'b1);
    build(6'b000000, 6'b100010, 5'd0, 1'b0, 0, 1'b0);

    @(posedge clock);
    #1;
    reset = 1'b1;
    applyStimulus();

    // Store stuck in MEM, then async reset mid-instruction
    opcode = 6'b101011; funct = 6'd0; rt = 5'd0;
    branch_taken = 1'b0; mem_ready = 1'b0; int_req = 1'b0;
    n = 0;
    while (state_a != 3'd3 && n < 10) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput("cycles_to_mem", 32'(n), 32'd3);
    @(negedge clock);
    checkOutput("mem_MemWrite", 32'(mwr_a), 32'd1);
    checkOutput("mem_MemRead",  32'(mrd_a), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("arst_MemWrite", 32'(mwr_a),   32'd0);
    checkOutput("arst_state",    32'(state_a), 32'd0);
    checkOutput("arst_PCWrite",  32'(pcw_a),   32'd0);
    checkOutput("arst_Wir",      32'(wir_a),   32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checkOutput($sformatf("post%0d_state_a", c), 32'(state_a), 32'(a_st[c]));
      checkOutput($sformatf("post%0d_Wir_a", c),   32'(wir_a),   32'(a_wir[c]));
      checkOutput($sformatf("post%0d_MemW_a", c),  32'(mwr_a),   32'(a_mwr[c]));
      checkOutput($sformatf("post%0d_state_b", c), 32'(state_b), 32'(b_st[c]));
      checkOutput($sformatf("post%0d_Wir_b", c),   32'(wir_b),   32'(b_wir[c]));
      @(posedge clock);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
